// File: rtl/vector_pkg.sv
// Shared helpers for the vector_mult family: result sizing and lane slicing.
package vector_pkg;

  // Wide enough for N worst-case DW x DW products summed without overflow.
  function automatic int resultWidth(input int dw, input int n);
    return 2 * dw + $clog2(n);
  endfunction

  function automatic int laneLsb(input int lane, input int dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/dot_adder_tree.sv
// Combinational beat partial: LANES extended multipliers feeding a binary adder tree.
module dot_adder_tree
  import vector_pkg::*;
#(
  parameter int LANES  = 2,
  parameter int DW     = 4,
  parameter int RW     = 2 * DW + 3,
  parameter int SIGNED = 0
) (
  input  logic [LANES*DW-1:0] a_i,
  input  logic [LANES*DW-1:0] b_i,
  output logic [RW-1:0]       sum_o
);

  // Heap-ordered tree: leaves at LANES-1.., node k sums children 2k+1 and 2k+2.
  logic [RW-1:0] node [2*LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : gLane
    logic [DW-1:0] aLane;
    logic [DW-1:0] bLane;
    logic [RW-1:0] aExt;
    logic [RW-1:0] bExt;
    assign aLane = a_i[laneLsb(i, DW) +: DW];
    assign bLane = b_i[laneLsb(i, DW) +: DW];
    assign aExt  = {{(RW-DW){(SIGNED != 0) && aLane[DW-1]}}, aLane};
    assign bExt  = {{(RW-DW){(SIGNED != 0) && bLane[DW-1]}}, bLane};
    assign node[LANES-1+i] = aExt * bExt;
  end

  for (genvar k = 0; k < LANES - 1; k++) begin : gNode
    assign node[k] = node[2*k+1] + node[2*k+2];
  end

  assign sum_o = node[0];

endmodule

// File: rtl/vector_dot_engine.sv
// Streaming dot-product engine: accumulates LANES-wide beats into one result per vector.
module vector_dot_engine
  import vector_pkg::*;
#(
  parameter int N      = 8,
  parameter int DW     = 4,
  parameter int LANES  = 2,
  parameter int SIGNED = 0,
  localparam int RW    = resultWidth(DW, N),
  localparam int BEATS = N / LANES,
  localparam int CW    = $clog2(BEATS) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_a,
  input  logic [LANES*DW-1:0] in_b,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [RW-1:0]       result,
  output logic [CW-1:0]       beat_cnt
);

  logic [RW-1:0] accQ, accD;
  logic [RW-1:0] resultQ, resultD;
  logic          resValidQ, resValidD;
  logic [CW-1:0] cntQ, cntD;
  logic [RW-1:0] partial;
  logic [RW-1:0] sum;
  logic          accept;
  logic          lastBeat;

  dot_adder_tree #(
    .LANES (LANES),
    .DW    (DW),
    .RW    (RW),
    .SIGNED(SIGNED)
  ) uTree (
    .a_i  (in_a),
    .b_i  (in_b),
    .sum_o(partial)
  );

  assign in_ready = !resValidQ || res_ready;
  assign accept   = in_valid && in_ready && !clr;
  assign lastBeat = (cntQ == CW'(BEATS - 1));
  // The first beat of a vector ignores acc so no separate clear cycle is needed.
  assign sum      = (cntQ == '0) ? partial : accQ + partial;

  always_comb begin
    accD      = accQ;
    cntD      = cntQ;
    resultD   = resultQ;
    resValidD = resValidQ;
    if (resValidQ && res_ready) begin
      resValidD = 1'b0;
    end
    if (clr) begin
      accD = '0;
      cntD = '0;
    end else if (accept) begin
      if (lastBeat) begin
        resultD   = sum;
        resValidD = 1'b1;
        accD      = '0;
        cntD      = '0;
      end else begin
        accD = sum;
        cntD = cntQ + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accQ      <= '0;
      cntQ      <= '0;
      resultQ   <= '0;
      resValidQ <= 1'b0;
    end else begin
      accQ      <= accD;
      cntQ      <= cntD;
      resultQ   <= resultD;
      resValidQ <= resValidD;
    end
  end

  assign result    = resultQ;
  assign res_valid = resValidQ;
  assign beat_cnt  = cntQ;

endmodule

// File: doc/vector_dot_engine.md
VECTOR_DOT_ENGINE -- requirements
Module: vector_dot_engine

Interface
REQ-001 Parameter N, default 8: elements per vector; power of two, N >= LANES.
REQ-002 Parameter DW, default 4: element width in bits.
REQ-003 Parameter LANES, default 2: elements consumed per accepted beat; power of two, divides N.
REQ-004 Parameter SIGNED, default 0: 0 means unsigned operands, 1 means two's-complement operands.
REQ-005 Derived constants: RW = 2*DW + $clog2(N) (result width); BEATS = N/LANES.
REQ-006 clk  input  1  clock; all state updates on the rising edge.
REQ-007 rst  input  1  reset; asynchronous, active-high.
REQ-008 clr  input  1  synchronous abort: discards the partial accumulation.
REQ-009 in_valid  input  1  beat offered.
REQ-010 in_ready  output  1  beat can be accepted.
REQ-011 in_a  input  LANES*DW  lane i at bits [i*DW +: DW].
REQ-012 in_b  input  LANES*DW  same packing as in_a.
REQ-013 res_valid  output  1  result held.
REQ-014 res_ready  input  1  consumer accepts the result.
REQ-015 result  output  RW  dot product; sign-extended when SIGNED=1.
REQ-016 beat_cnt  output  $clog2(BEATS)+1  beats accumulated in the current vector.

Function
REQ-017 A beat is accepted on a rising edge with in_valid && in_ready && !clr.
REQ-018 The beat partial equals the sum over lanes of in_a[i]*in_b[i], computed at full RW width with sign or zero extension per SIGNED.
REQ-019 On an accepted beat with beat_cnt < BEATS-1: acc <= (beat_cnt==0 ? partial : acc + partial); beat_cnt increments.
REQ-020 On an accepted beat with beat_cnt == BEATS-1: result <= acc + partial (partial alone when BEATS==1); res_valid <= 1; acc <= 0; beat_cnt <= 0.
REQ-021 Latency: result and res_valid are visible on the edge that accepts the last beat, one cycle after that beat is presented.
REQ-022 in_ready = !res_valid || res_ready; this is combinational, with no path from in_valid to in_ready.
REQ-023 res_valid clears on an edge with res_valid && res_ready, unless the same edge accepts a final beat; in that case result is overwritten and res_valid stays 1.
REQ-024 result holds stable while res_valid && !res_ready.
REQ-025 clr, when high: acc <= 0 and beat_cnt <= 0; any beat presented that cycle is dropped; res_valid and result are unaffected.
REQ-026 Arithmetic never overflows, because RW is sized for N worst-case products; no saturation logic is present.
REQ-027 Back-to-back vectors stream with no bubble while res_ready stays high.

Reset
REQ-028 While rst is high: result=0, res_valid=0, acc=0, beat_cnt=0.
REQ-029 in_ready is 1 while rst is high.
REQ-030 A reset mid-vector discards all partial state; the first beat after reset release starts a new vector.

Structure
REQ-031 A shared package vector_pkg contains the result-width function (2*DW+$clog2(N)) and the lane-slice helper; vector_mult-family blocks reuse it.
REQ-032 A single combinational sub-module, dot_adder_tree (LANES multipliers plus a log2 adder tree, SIGNED parameter), produces the partial.
REQ-033 The top level contains only the handshake, the beat counter, the accumulator and the result register; there are no other sub-modules.

Verification
All scenarios use N=4, DW=2, LANES=2, SIGNED=0 unless noted.
REQ-034 Stimulus: beats a=(3,2),b=(1,3) then a=(1,1),b=(2,2), res_ready=1. Response: result=13, res_valid high for one cycle, beat_cnt sequence 0,1,0.
REQ-035 Stimulus: all elements = 3 for both vectors. Response: result=36, which fits the 6-bit RW.
REQ-036 Stimulus: res_ready=0 after the first result (13); a second vector is offered. Response: in_ready=0, result holds 13. After res_ready=1 the second vector is accepted with no beats lost.
REQ-037 Stimulus: one beat accepted, then clr asserted together with in_valid; the next vector a=(1,1),(1,1), b=(1,1),(1,1). Response: result=4, and the clr-cycle beat is not counted.
REQ-038 Stimulus: rst pulsed asynchronously between beats. Response: outputs at reset values immediately; the following full vector yields its correct sum.
REQ-039 Stimulus: SIGNED=1, a=(-2,-2),(-2,-2), b=(-2,-2),(-2,-2). Response: result=+16; a=(-1,1),b=(1,1) twice gives result=0.
